lap_stop_timer: RTL and testbench
=================================

Name: lap_stop_timer

Overview:
- Parametrised stopwatch controller: programmable count width, tick prescaler, and a lap-capture FIFO.
- Same IDLE/RUNNING/PAUSED control model as the team's existing stopwatch. Adds lap timestamps, overflow reporting and a status output.
- Sits beside the system timer. Software-facing logic pops lap records through a valid/read handshake.

Parameters:
- WIDTH, 16, bit width of elapsed and of each lap record (range 2..32).
- PRESCALE, 1, clock cycles in RUNNING per elapsed increment (≥1; 1 = count every cycle).
- LAP_DEPTH, 4, lap FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; enter/resume RUNNING.
- stop  in  1  level-sampled; pause from RUNNING.
- clear  in  1  synchronous; zero count, flush laps, return to IDLE.
- lap  in  1  capture current elapsed into the lap FIFO.
- lap_rd  in  1  pop FIFO head when lap_valid=1.
- elapsed  out  WIDTH  current count.
- running  out  1  1 when state is RUNNING.
- lap_time  out  WIDTH  FIFO head (first-word-fall-through); 0 when empty.
- lap_valid  out  1  FIFO non-empty.
- lap_count  out  $clog2(LAP_DEPTH+1)  entries held.
- lap_drop  out  1  sticky; a lap was lost to a full FIFO.
- overflow  out  1  sticky; elapsed passed its maximum value.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, prescaler 0, FIFO emptied. All outputs 0.
- State transitions (evaluated each edge; clear has highest priority in every state):
  - IDLE: start → RUNNING.
  - RUNNING: stop → PAUSED. stop beats start when both are high.
  - PAUSED: start → RUNNING.
  - Any state: clear → IDLE.
- Counting:
  - The prescaler advances only on cycles where the registered state is RUNNING.
  - At PRESCALE−1 the prescaler returns to 0 and elapsed increments on the same edge.
  - Latency with PRESCALE=1: start sampled at edge k gives running=1 after edge k and elapsed=1 after edge k+1.
  - PAUSED holds both the prescaler and elapsed. Resume continues the partial prescale, with no restart.
  - IDLE holds elapsed. Only clear or reset zeroes it. start from IDLE continues from the held value.
- Width / wrap:
  - Increment from 2^WIDTH−1 wraps to 0 and sets overflow.
  - overflow stays set until clear or reset.
- clear:
  - Zeroes elapsed, prescaler, FIFO, lap_drop and overflow on the same edge.
  - Overrides start/stop/lap/lap_rd in that cycle.
- Lap capture:
  - lap in RUNNING or PAUSED pushes the registered elapsed value, i.e. before any same-edge increment.
  - lap in IDLE is ignored.
  - FIFO full with lap and no successful pop: record discarded, lap_drop set.
  - FIFO full with lap and lap_rd together: pop and push both succeed; count unchanged; no drop.
- Lap read:
  - lap_rd with lap_valid=0 is ignored.
  - lap_valid=0 with both lap and lap_rd: push only.
  - lap_time/lap_valid/lap_count update the edge after a push or pop.
- Mid-operation reset: immediate return to reset values regardless of state or FIFO contents.

Optional Feature:
- Macro: LAP_STOP_TIMER_SAT_EN.
- Defined:
  - elapsed saturates at 2^WIDTH−1 instead of wrapping.
  - overflow sets on the first attempted increment past max.
  - Timer remains RUNNING but the count holds.
- Undefined: wrap-to-0 behaviour as described above.

Test Plan:
- Reset, start for 1 cycle, wait 5 cycles, stop, wait 3 cycles (PRESCALE=1) → elapsed=5, running=0, held for 3 cycles. Start again → counts 6,7,…
- PRESCALE=3: run 10 cycles → elapsed=3, prescaler remainder 1. Pause 4 cycles, resume 2 cycles → elapsed=4.
- Laps taken at elapsed=2,5,9 → lap_count=3, lap_time=2. After lap_rd: lap_time=5, then 9, then lap_valid=0, lap_time=0.
- LAP_DEPTH=4: 5 laps without reads → lap_count=4, lap_drop=1, first 4 values retained. Lap+lap_rd while full → count stays 4, lap_drop unchanged.
- WIDTH=4: run 17 counts → elapsed=1, overflow=1. With LAP_STOP_TIMER_SAT_EN → elapsed=15, overflow=1.
- Running with 2 laps stored; assert clear with start and lap in the same cycle → IDLE, elapsed=0, FIFO empty, flags 0. Assert rst_n=0 mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/lap_stop_timer_if.sv
// Lap-stop-timer bus: control strobes from software side, count/status and
// lap-FIFO read handshake back from the timer.
interface lap_stop_timer_if #(
    parameter int WIDTH     = 16,
    parameter int LAP_DEPTH = 4
);
    logic                               start;
    logic                               stop;
    logic                               clear;
    logic                               lap;
    logic                               lap_rd;
    logic [WIDTH-1:0]                   elapsed;
    logic                               running;
    logic [WIDTH-1:0]                   lap_time;
    logic                               lap_valid;
    logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count;
    logic                               lap_drop;
    logic                               overflow;

    modport master (
        output start, stop, clear, lap, lap_rd,
        input  elapsed, running, lap_time, lap_valid, lap_count, lap_drop, overflow
    );

    modport slave (
        input  start, stop, clear, lap, lap_rd,
        output elapsed, running, lap_time, lap_valid, lap_count, lap_drop, overflow
    );
endinterface

// File: rtl/lap_stop_timer.sv
// Stopwatch with IDLE/RUNNING/PAUSED control, tick prescaler and a
// first-word-fall-through lap FIFO. Sticky lap_drop and overflow flags.
// Build option: define LAP_STOP_TIMER_SAT_EN to make elapsed saturate at its
// maximum instead of wrapping to zero (overflow still flags the event).
module lap_stop_timer #(
    parameter int WIDTH     = 16,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    lap_stop_timer_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    localparam logic [PW-1:0]    PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(LAP_DEPTH);
    localparam logic [WIDTH-1:0] E_MAX    = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic [WIDTH-1:0] elapsed_q, elapsed_d;
    logic             ovf_q,     ovf_d;
    logic             drop_q,    drop_d;
    logic             running_q, running_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] head_q,    head_d;
    logic [WIDTH-1:0] mem_q [LAP_DEPTH];

    logic tick_s;
    logic lap_req_s;
    logic push_s;
    logic pop_s;

    // Next-state logic: control FSM, prescaler/count, lap FIFO bookkeeping.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        elapsed_d = elapsed_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        running_d = running_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tick_s    = 1'b0;
        lap_req_s = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;

        if (bus.clear) begin
            // clear wins over every other request in the same cycle
            state_d   = S_IDLE;
            presc_d   = '0;
            elapsed_d = '0;
            ovf_d     = 1'b0;
            drop_d    = 1'b0;
            running_d = 1'b0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            head_d    = '0;
        end else begin
            case (state_q)
                S_IDLE:  state_d = bus.start ? S_RUN : S_IDLE;
                S_RUN:   state_d = bus.stop  ? S_PAUSE : S_RUN;
                S_PAUSE: state_d = bus.start ? S_RUN : S_PAUSE;
                default: state_d = S_IDLE;
            endcase
            running_d = (state_d == S_RUN);

            // prescaler only moves while the registered state is RUNNING,
            // so a pause keeps the partial prescale for the resume
            if (state_q == S_RUN) begin
                if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    tick_s  = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end else begin
                presc_d = presc_q;
            end

            if (tick_s) begin
                if (elapsed_q == E_MAX) begin
                    ovf_d = 1'b1;
`ifdef LAP_STOP_TIMER_SAT_EN
                    elapsed_d = elapsed_q;
`else
                    elapsed_d = '0;
`endif
                end else begin
                    elapsed_d = elapsed_q + WIDTH'(1);
                end
            end else begin
                elapsed_d = elapsed_q;
            end

            // a full FIFO still accepts a lap when the head leaves this cycle
            pop_s     = bus.lap_rd && (cnt_q != '0);
            lap_req_s = bus.lap && (state_q != S_IDLE);
            push_s    = lap_req_s && ((cnt_q != CNT_FULL) || pop_s);

            if (lap_req_s && !push_s) begin
                drop_d = 1'b1;
            end else begin
                drop_d = drop_q;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase

            // registered head: bypass the record being written when it
            // lands exactly in the slot that becomes the new head
            if (cnt_d == '0) begin
                head_d = '0;
            end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
                head_d = elapsed_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // State, count, flags and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            elapsed_q <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
            running_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            running_q <= running_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= elapsed_q;
            end
        end
    end

    assign bus.elapsed   = elapsed_q;
    assign bus.running   = running_q;
    assign bus.lap_time  = head_q;
    assign bus.lap_valid = (cnt_q != '0);
    assign bus.lap_count = cnt_q;
    assign bus.lap_drop  = drop_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_lap_stop_timer.sv
// Directed bench: three timer instances (basic/lap, prescale-3, 4-bit width).
module tb_lap_stop_timer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lap_stop_timer_if #(.WIDTH(16), .LAP_DEPTH(4)) if_a();
    lap_stop_timer_if #(.WIDTH(16), .LAP_DEPTH(4)) if_b();
    lap_stop_timer_if #(.WIDTH(4),  .LAP_DEPTH(4)) if_c();

    lap_stop_timer #(.WIDTH(16), .PRESCALE(1), .LAP_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    lap_stop_timer #(.WIDTH(16), .PRESCALE(3), .LAP_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    lap_stop_timer #(.WIDTH(4),  .PRESCALE(1), .LAP_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {if_a.start, if_a.stop, if_a.clear, if_a.lap, if_a.lap_rd} = 5'b0;
        {if_b.start, if_b.stop, if_b.clear, if_b.lap, if_b.lap_rd} = 5'b0;
        {if_c.start, if_c.stop, if_c.clear, if_c.lap, if_c.lap_rd} = 5'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        total++;
        if ({if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
             if_a.lap_count, if_a.lap_drop, if_a.overflow} !== 39'd0) begin
            bad++;
            $display("FAIL reset_a elapsed=%0d run=%0b time=%0d valid=%0b cnt=%0d drop=%0b ovf=%0b required all 0",
                     if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
                     if_a.lap_count, if_a.lap_drop, if_a.overflow);
        end
        total++;
        if (if_b.elapsed !== 16'd0 || if_c.elapsed !== 4'd0 || if_c.overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_bc b_elapsed=%0d c_elapsed=%0d c_ovf=%0b required 0",
                     if_b.elapsed, if_c.elapsed, if_c.overflow);
        end
    endtask

    task automatic test_basic();
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        total++;
        if (if_a.running !== 1'b1 || if_a.elapsed !== 16'd0) begin
            bad++;
            $display("FAIL start_latency run=%0b elapsed=%0d required 1/0", if_a.running, if_a.elapsed);
        end
        step(4);
        if_a.stop = 1'b1;
        step(1);
        if_a.stop = 1'b0;
        total++;
        if (if_a.elapsed !== 16'd5 || if_a.running !== 1'b0) begin
            bad++;
            $display("FAIL stop elapsed=%0d run=%0b required 5/0", if_a.elapsed, if_a.running);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (if_a.elapsed !== 16'd5 || if_a.running !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold cyc=%0d elapsed=%0d run=%0b required 5/0",
                         i, if_a.elapsed, if_a.running);
            end
        end
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        total++;
        if (if_a.running !== 1'b1 || if_a.elapsed !== 16'd5) begin
            bad++;
            $display("FAIL resume run=%0b elapsed=%0d required 1/5", if_a.running, if_a.elapsed);
        end
        step(1);
        total++;
        if (if_a.elapsed !== 16'd6) begin
            bad++;
            $display("FAIL resume_count1 elapsed=%0d required 6", if_a.elapsed);
        end
        step(1);
        total++;
        if (if_a.elapsed !== 16'd7) begin
            bad++;
            $display("FAIL resume_count2 elapsed=%0d required 7", if_a.elapsed);
        end
        if_a.start = 1'b1;
        if_a.stop  = 1'b1;
        step(1);
        if_a.start = 1'b0;
        if_a.stop  = 1'b0;
        total++;
        if (if_a.running !== 1'b0 || if_a.elapsed !== 16'd8) begin
            bad++;
            $display("FAIL stop_beats_start run=%0b elapsed=%0d required 0/8", if_a.running, if_a.elapsed);
        end
    endtask

    task automatic test_prescale();
        if_b.start = 1'b1;
        step(1);
        if_b.start = 1'b0;
        step(9);
        total++;
        if (if_b.elapsed !== 16'd3) begin
            bad++;
            $display("FAIL presc_run9 elapsed=%0d required 3", if_b.elapsed);
        end
        if_b.stop = 1'b1;
        step(1);
        if_b.stop = 1'b0;
        step(4);
        total++;
        if (if_b.elapsed !== 16'd3 || if_b.running !== 1'b0) begin
            bad++;
            $display("FAIL presc_pause elapsed=%0d run=%0b required 3/0", if_b.elapsed, if_b.running);
        end
        if_b.start = 1'b1;
        step(1);
        if_b.start = 1'b0;
        step(1);
        total++;
        if (if_b.elapsed !== 16'd3) begin
            bad++;
            $display("FAIL presc_resume1 elapsed=%0d required 3", if_b.elapsed);
        end
        step(1);
        total++;
        if (if_b.elapsed !== 16'd4) begin
            bad++;
            $display("FAIL presc_resume2 elapsed=%0d required 4", if_b.elapsed);
        end
    endtask

    task automatic test_laps();
        logic [15:0] exp_t [3];
        exp_t[0] = 16'd5; exp_t[1] = 16'd9; exp_t[2] = 16'd0;
        if_a.clear = 1'b1;
        step(1);
        if_a.clear = 1'b0;
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        step(2);
        if_a.lap = 1'b1;
        step(1);
        if_a.lap = 1'b0;
        total++;
        if (if_a.lap_time !== 16'd2 || if_a.lap_valid !== 1'b1 || if_a.lap_count !== 3'd1) begin
            bad++;
            $display("FAIL lap_first time=%0d valid=%0b cnt=%0d required 2/1/1",
                     if_a.lap_time, if_a.lap_valid, if_a.lap_count);
        end
        step(2);
        if_a.lap = 1'b1;
        step(1);
        if_a.lap = 1'b0;
        step(3);
        if_a.lap = 1'b1;
        step(1);
        if_a.lap = 1'b0;
        if_a.stop = 1'b1;
        step(1);
        if_a.stop = 1'b0;
        total++;
        if (if_a.lap_count !== 3'd3 || if_a.lap_time !== 16'd2 || if_a.elapsed !== 16'd11) begin
            bad++;
            $display("FAIL lap_three cnt=%0d time=%0d elapsed=%0d required 3/2/11",
                     if_a.lap_count, if_a.lap_time, if_a.elapsed);
        end
        if_a.lap_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (if_a.lap_time !== exp_t[i] || if_a.lap_count !== 3'(2 - i) ||
                if_a.lap_valid !== (i < 2)) begin
                bad++;
                $display("FAIL lap_pop%0d time=%0d cnt=%0d valid=%0b required %0d/%0d/%0b",
                         i, if_a.lap_time, if_a.lap_count, if_a.lap_valid, exp_t[i], 2 - i, i < 2);
            end
        end
        step(1);
        if_a.lap_rd = 1'b0;
        total++;
        if (if_a.lap_count !== 3'd0 || if_a.lap_time !== 16'd0) begin
            bad++;
            $display("FAIL pop_empty cnt=%0d time=%0d required 0/0", if_a.lap_count, if_a.lap_time);
        end
    endtask

    task automatic test_drop();
        logic [15:0] exp_t [4];
        exp_t[0] = 16'd4; exp_t[1] = 16'd5; exp_t[2] = 16'd8; exp_t[3] = 16'd0;
        if_a.clear = 1'b1;
        step(1);
        if_a.clear = 1'b0;
        if_a.lap = 1'b1;
        step(1);
        total++;
        if (if_a.lap_count !== 3'd0 || if_a.lap_drop !== 1'b0) begin
            bad++;
            $display("FAIL lap_idle cnt=%0d drop=%0b required 0/0", if_a.lap_count, if_a.lap_drop);
        end
        if_a.lap = 1'b0;
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        step(2);
        if_a.lap = 1'b1;
        step(5);
        if_a.lap = 1'b0;
        if_a.stop = 1'b1;
        step(1);
        if_a.stop = 1'b0;
        total++;
        if (if_a.lap_count !== 3'd4 || if_a.lap_drop !== 1'b1 || if_a.lap_time !== 16'd2) begin
            bad++;
            $display("FAIL fifo_full cnt=%0d drop=%0b time=%0d required 4/1/2",
                     if_a.lap_count, if_a.lap_drop, if_a.lap_time);
        end
        if_a.lap = 1'b1;
        if_a.lap_rd = 1'b1;
        step(1);
        if_a.lap = 1'b0;
        total++;
        if (if_a.lap_count !== 3'd4 || if_a.lap_drop !== 1'b1 || if_a.lap_time !== 16'd3) begin
            bad++;
            $display("FAIL full_push_pop cnt=%0d drop=%0b time=%0d required 4/1/3",
                     if_a.lap_count, if_a.lap_drop, if_a.lap_time);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++;
            if (if_a.lap_time !== exp_t[i] || if_a.lap_count !== 3'(3 - i)) begin
                bad++;
                $display("FAIL drain%0d time=%0d cnt=%0d required %0d/%0d",
                         i, if_a.lap_time, if_a.lap_count, exp_t[i], 3 - i);
            end
        end
        if_a.lap_rd = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_w0;
        logic [3:0] exp_w1;
`ifdef LAP_STOP_TIMER_SAT_EN
        exp_w0 = 4'd15;
        exp_w1 = 4'd15;
`else
        exp_w0 = 4'd0;
        exp_w1 = 4'd1;
`endif
        if_c.start = 1'b1;
        step(1);
        if_c.start = 1'b0;
        step(15);
        total++;
        if (if_c.elapsed !== 4'd15 || if_c.overflow !== 1'b0) begin
            bad++;
            $display("FAIL at_max elapsed=%0d ovf=%0b required 15/0", if_c.elapsed, if_c.overflow);
        end
        step(1);
        total++;
        if (if_c.elapsed !== exp_w0 || if_c.overflow !== 1'b1) begin
            bad++;
            $display("FAIL past_max elapsed=%0d ovf=%0b required %0d/1", if_c.elapsed, if_c.overflow, exp_w0);
        end
        step(1);
        total++;
        if (if_c.elapsed !== exp_w1 || if_c.overflow !== 1'b1 || if_c.running !== 1'b1) begin
            bad++;
            $display("FAIL count17 elapsed=%0d ovf=%0b run=%0b required %0d/1/1",
                     if_c.elapsed, if_c.overflow, if_c.running, exp_w1);
        end
        if_c.clear = 1'b1;
        step(1);
        if_c.clear = 1'b0;
        total++;
        if (if_c.elapsed !== 4'd0 || if_c.overflow !== 1'b0 || if_c.running !== 1'b0) begin
            bad++;
            $display("FAIL wrap_clear elapsed=%0d ovf=%0b run=%0b required 0/0/0",
                     if_c.elapsed, if_c.overflow, if_c.running);
        end
    endtask

    task automatic test_clear();
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        if_a.lap = 1'b1;
        step(2);
        if_a.lap = 1'b0;
        total++;
        if (if_a.lap_count !== 3'd2 || if_a.lap_drop !== 1'b1 || if_a.running !== 1'b1) begin
            bad++;
            $display("FAIL pre_clear cnt=%0d drop=%0b run=%0b required 2/1/1",
                     if_a.lap_count, if_a.lap_drop, if_a.running);
        end
        if_a.clear = 1'b1;
        if_a.start = 1'b1;
        if_a.lap   = 1'b1;
        step(1);
        if_a.clear = 1'b0;
        if_a.start = 1'b0;
        if_a.lap   = 1'b0;
        total++;
        if ({if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
             if_a.lap_count, if_a.lap_drop, if_a.overflow} !== 39'd0) begin
            bad++;
            $display("FAIL clear_priority elapsed=%0d run=%0b time=%0d valid=%0b cnt=%0d drop=%0b required all 0",
                     if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
                     if_a.lap_count, if_a.lap_drop);
        end
        step(1);
        total++;
        if (if_a.elapsed !== 16'd0 || if_a.running !== 1'b0) begin
            bad++;
            $display("FAIL clear_idle elapsed=%0d run=%0b required 0/0", if_a.elapsed, if_a.running);
        end
    endtask

    task automatic test_async_reset();
        if_a.start = 1'b1;
        step(1);
        if_a.start = 1'b0;
        step(3);
        if_a.lap = 1'b1;
        step(1);
        if_a.lap = 1'b0;
        total++;
        if (if_a.elapsed !== 16'd4 || if_a.lap_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset elapsed=%0d valid=%0b required 4/1", if_a.elapsed, if_a.lap_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
             if_a.lap_count, if_a.lap_drop, if_a.overflow} !== 39'd0 || if_b.elapsed !== 16'd0) begin
            bad++;
            $display("FAIL async_reset elapsed=%0d run=%0b time=%0d valid=%0b cnt=%0d b_elapsed=%0d required all 0",
                     if_a.elapsed, if_a.running, if_a.lap_time, if_a.lap_valid,
                     if_a.lap_count, if_b.elapsed);
        end
        #2;
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_prescale();
        test_laps();
        test_drop();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
